tile_pp_sched: RTL and testbench

Ping-pong tile scheduler for the activation input buffer. For each conv layer it takes the tile count from the parameter controller and issues tile-load requests to the buffer writer. It also issues compute starts to the inbuff address generator / PE side, and tracks the state of the two buffer banks so that loading of tile n+1 overlaps computation of tile n. It pulses `layer_done` when the last tile of the layer has been computed.

---
 rtl/tile_pp_sched.sv | 159 +++++++++++++++
 tb/tb_tile_pp_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pp_sched.sv
// Ping-pong tile scheduler: overlaps the load of tile n+1 into one activation
// bank with the compute of tile n out of the other bank, one layer at a time.
module tile_pp_sched #(
  parameter int TILE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] tile_total,
  output logic              load_req,
  output logic              load_bank,
  input  logic              load_done,
  output logic              comp_start,
  output logic              comp_bank,
  output logic              comp_last,
  input  logic              comp_done,
  output logic              layer_done,
  output logic              busy,
  output logic [TILE_W-1:0] tiles_loaded,
  output logic [TILE_W-1:0] tiles_computed,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_banks
);

  // Handshake: load_req/comp_start are single-cycle requests; each owns one
  // outstanding slot that only the matching single-cycle *_done pulse frees.
  // A *_done arriving with no request outstanding is dropped.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] B_EMPTY   = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_FULL    = 2'd2;
  localparam logic [1:0] B_READING = 2'd3;

  localparam logic [TILE_W-1:0] ONE = TILE_W'(1);

  logic [1:0]        state;
  logic [TILE_W-1:0] total;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              load_out;
  logic              comp_out;
  logic [1:0]        bank_st [2];

  logic [1:0]        wr_bank_st;
  logic [1:0]        rd_bank_st;
  logic              load_issue;
  logic              comp_issue;
  logic [TILE_W-1:0] computed_next;
  logic              last_tile;

  // Issue decisions look only at registered state, so a bank freed by
  // comp_done on one edge is reloaded no earlier than the following edge.
  always_comb begin
    wr_bank_st    = wr_ptr ? bank_st[1] : bank_st[0];
    rd_bank_st    = rd_ptr ? bank_st[1] : bank_st[0];
    load_issue    = (state == S_RUN) && (tiles_loaded < total) &&
                    (wr_bank_st == B_EMPTY) && !load_out;
    comp_issue    = (state == S_RUN) && (rd_bank_st == B_FULL) && !comp_out;
    computed_next = tiles_computed + ONE;
    last_tile     = (computed_next == total);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      total          <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      load_out       <= 1'b0;
      comp_out       <= 1'b0;
      bank_st[0]     <= B_EMPTY;
      bank_st[1]     <= B_EMPTY;
      load_req       <= 1'b0;
      load_bank      <= 1'b0;
      comp_start     <= 1'b0;
      comp_bank      <= 1'b0;
      comp_last      <= 1'b0;
      layer_done     <= 1'b0;
      busy           <= 1'b0;
      tiles_loaded   <= '0;
      tiles_computed <= '0;
    end else begin
      load_req   <= load_issue;
      comp_start <= comp_issue;
      comp_last  <= comp_issue && last_tile;
      layer_done <= 1'b0;

      if (load_issue) begin
        load_bank           <= wr_ptr;
        bank_st[wr_ptr]     <= B_FILLING;
        tiles_loaded        <= tiles_loaded + ONE;
        load_out            <= 1'b1;
      end
      if (load_done && load_out) begin
        bank_st[wr_ptr]     <= B_FULL;
        wr_ptr              <= ~wr_ptr;
        load_out            <= 1'b0;
      end

      if (comp_issue) begin
        comp_bank           <= rd_ptr;
        bank_st[rd_ptr]     <= B_READING;
        comp_out            <= 1'b1;
      end
      if (comp_done && comp_out) begin
        bank_st[rd_ptr]     <= B_EMPTY;
        rd_ptr              <= ~rd_ptr;
        comp_out            <= 1'b0;
        tiles_computed      <= computed_next;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            total          <= tile_total;
            tiles_loaded   <= '0;
            tiles_computed <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            load_out       <= 1'b0;
            comp_out       <= 1'b0;
            bank_st[0]     <= B_EMPTY;
            bank_st[1]     <= B_EMPTY;
            busy           <= 1'b1;
            // An empty layer skips RUN and reports completion straight away.
            if (tile_total == '0) begin
              state      <= S_FIN;
              layer_done <= 1'b1;
            end else begin
              state      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (tiles_computed == total) begin
            state      <= S_FIN;
            layer_done <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_banks = {bank_st[1], bank_st[0]};

endmodule

// File: tb/tb_tile_pp_sched.sv
// Self-checking bench for tile_pp_sched: tile-index reference model compared
// every cycle, reactive writer/compute responders, directed and random layers.
module tb_tile_pp_sched;

  localparam int TILE_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [TILE_W-1:0] tile_total = '0;
  logic              load_done = 1'b0;
  logic              comp_done = 1'b0;
  logic              load_req, load_bank, comp_start, comp_bank, comp_last;
  logic              layer_done, busy;
  logic [TILE_W-1:0] tiles_loaded, tiles_computed;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_banks;

  always #5 clk = ~clk;

  tile_pp_sched #(.TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_total(tile_total),
    .load_req(load_req), .load_bank(load_bank), .load_done(load_done),
    .comp_start(comp_start), .comp_bank(comp_bank), .comp_last(comp_last),
    .comp_done(comp_done), .layer_done(layer_done), .busy(busy),
    .tiles_loaded(tiles_loaded), .tiles_computed(tiles_computed),
    .dbg_state(dbg_state), .dbg_banks(dbg_banks)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- reference model (tile indices, not banks) ----------------
  int m_phase = 0;
  int m_total = 0;
  int m_issued = 0, m_landed = 0, m_started = 0, m_done = 0;
  int e_load_req = 0, e_load_bank = 0, e_comp_start = 0, e_comp_bank = 0;
  int e_comp_last = 0, e_layer_done = 0, e_busy = 0;
  logic m_lfire, m_cfire;

  // Tile k lives in bank k%2; its bank is free once tile k-2 has been computed.
  always_comb begin
    m_lfire = 1'b0;
    m_cfire = 1'b0;
    if (m_phase == 1) begin
      m_lfire = (m_issued < m_total) && (m_issued == m_landed) &&
                (m_issued < 2 || m_done >= m_issued - 1);
      m_cfire = (m_started < m_landed) && (m_started == m_done);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_total <= 0;
      m_issued <= 0; m_landed <= 0; m_started <= 0; m_done <= 0;
      e_load_req <= 0; e_load_bank <= 0; e_comp_start <= 0; e_comp_bank <= 0;
      e_comp_last <= 0; e_layer_done <= 0; e_busy <= 0;
    end else begin
      e_load_req   <= int'(m_lfire);
      e_comp_start <= int'(m_cfire);
      e_comp_last  <= int'(m_cfire && (m_started + 1 == m_total));
      e_layer_done <= 0;
      if (m_lfire) begin
        e_load_bank <= m_issued % 2;
        m_issued    <= m_issued + 1;
      end
      if (load_done && m_issued > m_landed) m_landed <= m_landed + 1;
      if (m_cfire) begin
        e_comp_bank <= m_started % 2;
        m_started   <= m_started + 1;
      end
      if (comp_done && m_started > m_done) m_done <= m_done + 1;
      case (m_phase)
        0: if (start) begin
             m_total <= int'(tile_total);
             m_issued <= 0; m_landed <= 0; m_started <= 0; m_done <= 0;
             e_busy <= 1;
             if (tile_total == 0) begin
               m_phase <= 2; e_layer_done <= 1;
             end else begin
               m_phase <= 1;
             end
           end
        1: if (m_done == m_total) begin
             m_phase <= 2; e_layer_done <= 1;
           end
        default: begin
          m_phase <= 0; e_busy <= 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("load_req",       load_req,       e_load_req);
      chk("load_bank",      load_bank,      e_load_bank);
      chk("comp_start",     comp_start,     e_comp_start);
      chk("comp_bank",      comp_bank,      e_comp_bank);
      chk("comp_last",      comp_last,      e_comp_last);
      chk("layer_done",     layer_done,     e_layer_done);
      chk("busy",           busy,           e_busy);
      chk("tiles_loaded",   tiles_loaded,   m_issued);
      chk("tiles_computed", tiles_computed, m_done);
    end
  end

  // ---------------- writer / compute responders ----------------
  int ld_cnt = 0, cp_cnt = 0;
  int wr_lo = 1, wr_hi = 1, cp_lo = 1, cp_hi = 1;
  bit spur_ld = 0, spur_cp = 0;
  int simul_edge = -1;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      load_done = 1'b0;
      comp_done = 1'b0;
      if (!rst) begin
        ld_cnt = 0;
        cp_cnt = 0;
      end else begin
        if (load_req)   ld_cnt = $urandom_range(wr_hi, wr_lo);
        if (comp_start) cp_cnt = $urandom_range(cp_hi, cp_lo);
        if (ld_cnt == 1) load_done = 1'b1;
        if (ld_cnt > 0)  ld_cnt--;
        if (cp_cnt == 1) comp_done = 1'b1;
        if (cp_cnt > 0)  cp_cnt--;
        if (spur_ld) begin load_done = 1'b1; spur_ld = 0; end
        if (spur_cp) begin comp_done = 1'b1; spur_cp = 0; end
        if (load_done && comp_done) simul_edge = cyc + 1;
      end
    end
  end

  // ---------------- event logs and protocol monitor ----------------
  int lb_q[$], lr_cyc_q[$], cb_q[$], cl_q[$], cc_q[$];
  int ld_count = 0, ld_cyc = -1, viol = 0;
  int n_lr = 0, n_ld = 0, n_cs = 0;
  logic [3:0] snap_banks = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (comp_start && n_cs >= n_ld) viol++;
      if (load_req && n_lr > n_ld) viol++;
      if (load_done && n_ld < n_lr) n_ld++;
      if (load_req) begin
        n_lr++;
        lb_q.push_back(int'(load_bank));
        lr_cyc_q.push_back(cyc);
      end
      if (comp_start) begin
        n_cs++;
        cb_q.push_back(int'(comp_bank));
        cl_q.push_back(int'(comp_last));
        cc_q.push_back(cyc);
      end
      if (layer_done) begin
        ld_count++;
        ld_cyc = cyc;
      end
      if (cyc == simul_edge) snap_banks = dbg_banks;
    end
  end

  task automatic clear_logs();
    lb_q.delete(); lr_cyc_q.delete(); cb_q.delete(); cl_q.delete(); cc_q.delete();
    ld_count = 0; ld_cyc = -1; viol = 0;
    n_lr = 0; n_ld = 0; n_cs = 0;
    simul_edge = -1;
  endtask

  int st_edge = 0;

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("layer_finished_in_budget", busy, 1'b0);
  endtask

  // Caller sits on a negedge with the block idle, so start lands back-to-back.
  task automatic run_layer(input int t, input int budget);
    clear_logs();
    start = 1'b1;
    tile_total = t[TILE_W-1:0];
    st_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    tile_total = '0;
    wait_idle(budget);
  endtask

  task automatic set_lat(input int wl, input int wh, input int cl, input int ch);
    wr_lo = wl; wr_hi = wh; cp_lo = cl; cp_hi = ch;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load_req"},   load_req,   1'b0);
    chk({tag, "_load_bank"},  load_bank,  1'b0);
    chk({tag, "_comp_start"}, comp_start, 1'b0);
    chk({tag, "_comp_bank"},  comp_bank,  1'b0);
    chk({tag, "_comp_last"},  comp_last,  1'b0);
    chk({tag, "_layer_done"}, layer_done, 1'b0);
    chk({tag, "_busy"},       busy,       1'b0);
    chk({tag, "_tiles_ld"},   tiles_loaded,   '0);
    chk({tag, "_tiles_cp"},   tiles_computed, '0);
    chk({tag, "_banks"},      dbg_banks,  4'h0);
    chk({tag, "_state"},      dbg_state,  2'd0);
  endtask

  initial begin
    int t;
    // Power-up reset.
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b1;
    @(negedge clk);

    // Three tiles, writer 4 cycles, compute 10 cycles.
    set_lat(4, 4, 10, 10);
    run_layer(3, 300);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_load_bank%0d", i), at(lb_q, i), (i == 1) ? 1 : 0);
      chk($sformatf("t3_comp_bank%0d", i), at(cb_q, i), (i == 1) ? 1 : 0);
      chk($sformatf("t3_comp_last%0d", i), at(cl_q, i), (i == 2) ? 1 : 0);
    end
    chk("t3_load_count",  lb_q.size(), 3);
    chk("t3_first_load",  at(lr_cyc_q, 0), st_edge + 1);
    chk("t3_first_comp",  at(cc_q, 0), st_edge + 6);
    chk("t3_last_comp",   at(cc_q, 2), st_edge + 28);
    chk("t3_layer_cycle", ld_cyc, st_edge + 39);
    chk("t3_layer_count", ld_count, 1);
    chk("t3_tiles_ld",    tiles_loaded, 3);
    chk("t3_tiles_cp",    tiles_computed, 3);

    // Slow writer, fast compute.
    set_lat(20, 20, 2, 2);
    run_layer(4, 400);
    chk("t4_protocol_viol", viol, 0);
    chk("t4_load_count",    lb_q.size(), 4);
    chk("t4_load_bank3",    at(lb_q, 3), 1);
    chk("t4_layer_count",   ld_count, 1);
    chk("t4_tiles_cp",      tiles_computed, 4);

    // load_done of tile 1 and comp_done of tile 0 on the same edge.
    set_lat(3, 3, 3, 3);
    run_layer(2, 200);
    chk("sim_edge",        simul_edge, st_edge + 8);
    chk("sim_banks",       snap_banks, 4'h8);
    chk("sim_comp1_bank",  at(cb_q, 1), 1);
    chk("sim_comp1_cycle", at(cc_q, 1), simul_edge + 1);
    chk("sim_comp1_last",  at(cl_q, 1), 1);
    chk("sim_load_count",  lb_q.size(), 2);

    // Empty layer.
    run_layer(0, 20);
    chk("t0_layer_cycle", ld_cyc, st_edge);
    chk("t0_layer_count", ld_count, 1);
    chk("t0_loads",       lb_q.size(), 0);
    chk("t0_comps",       cb_q.size(), 0);

    // Restart during RUN is ignored; spurious done pulses in IDLE are ignored.
    set_lat(2, 2, 3, 3);
    clear_logs();
    start = 1'b1; tile_total = 5'd5; st_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0; tile_total = '0;
    repeat (5) @(negedge clk);
    start = 1'b1; tile_total = 5'd7;
    @(negedge clk);
    start = 1'b0; tile_total = '0;
    wait_idle(300);
    chk("rs_tiles_ld",    tiles_loaded, 5);
    chk("rs_tiles_cp",    tiles_computed, 5);
    chk("rs_layer_count", ld_count, 1);
    @(posedge clk); spur_cp = 1;
    @(posedge clk); spur_ld = 1;
    repeat (3) @(negedge clk);
    chk("sp_tiles_ld",    tiles_loaded, 5);
    chk("sp_tiles_cp",    tiles_computed, 5);
    chk("sp_busy",        busy, 1'b0);
    chk("sp_state",       dbg_state, 2'd0);
    chk("sp_layer_count", ld_count, 1);

    // Reset mid-RUN with bank 0 READING and bank 1 FULL.
    set_lat(1, 1, 20, 20);
    clear_logs();
    start = 1'b1; tile_total = 5'd6;
    @(negedge clk);
    start = 1'b0; tile_total = '0;
    repeat (9) @(negedge clk);
    chk("mid_banks", dbg_banks, 4'hB);
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_lat(2, 2, 2, 2);
    run_layer(2, 200);
    chk("post_rst_load_bank0", at(lb_q, 0), 0);
    chk("post_rst_load_bank1", at(lb_q, 1), 1);
    chk("post_rst_comp_bank0", at(cb_q, 0), 0);
    chk("post_rst_comp_bank1", at(cb_q, 1), 1);
    chk("post_rst_layer",      ld_count, 1);
    chk("post_rst_tiles_cp",   tiles_computed, 2);

    // Random layers, including the largest tile count.
    for (int i = 0; i < 10; i++) begin
      t = (i == 0) ? 31 : $urandom_range(12, 1);
      set_lat(1, $urandom_range(8, 1), 1, $urandom_range(8, 1));
      run_layer(t, 2000);
      chk($sformatf("rnd%0d_tiles_ld", i), tiles_loaded, t);
      chk($sformatf("rnd%0d_tiles_cp", i), tiles_computed, t);
      chk($sformatf("rnd%0d_viol", i), viol, 0);
      chk($sformatf("rnd%0d_layers", i), ld_count, 1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
